nibble_deserializer: RTL and testbench

NIBBLE_DESERIALIZER -- requirements
Module: nibble_deserializer

---
 rtl/nibble_deser_pkg.sv | 29 ++
 rtl/nibble_deser_timer.sv | 30 +++
 rtl/nibble_deserializer.sv | 158 +++++++++++++++
 tb/tb_nibble_deserializer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_deser_pkg.sv
// Shared types for the nibble deserializer.
// NIBBLE_DESER_PARITY_EN adds the PARITY state and the even-parity helper.
package nibble_deser_pkg;

  localparam int NIBBLE_W = 4;

  typedef logic [NIBBLE_W-1:0] nibble_t;

`ifdef NIBBLE_DESER_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_LOAD   = 2'd3
  } state_t;

  // True when data plus parity bit holds an even number of ones.
  function automatic logic parity_ok(input nibble_t data, input logic pbit);
    return ~(^{data, pbit});
  endfunction
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd3
  } state_t;
`endif

endpackage

// File: rtl/nibble_deser_timer.sv
// Inactivity timer: down-counter reloaded on clear, decremented on run;
// expired flags the cycle that would be the TIMEOUT_CYCLES-th consecutive run.
module nibble_deser_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam logic [7:0] RELOAD = 8'(TIMEOUT_CYCLES);

  // Holding RELOAD means no idle cycles have been counted yet.
  logic [7:0] remain;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      remain <= RELOAD;
    end else if (clear) begin
      remain <= RELOAD;
    end else if (run && (remain != 8'd0)) begin
      remain <= remain - 8'd1;
    end
  end

  assign expired = run && (remain == 8'd1);

endmodule

// File: rtl/nibble_deserializer.sv
// Serial-to-nibble deserializer with START framing, inactivity timeout and
// registered outputs. Optional parity frame bit under NIBBLE_DESER_PARITY_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for START with SIN_VALID
// ST_SHIFT  | collecting data bits 2..4, watching for timeout/restart
// ST_PARITY | collecting the even-parity bit (NIBBLE_DESER_PARITY_EN)
// ST_LOAD   | LOAD_EN cycle; a START here opens the next frame directly
module nibble_deserializer
  import nibble_deser_pkg::*;
#(
  parameter int unsigned MSB_FIRST      = 1,
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                SIN,
  input  logic                SIN_VALID,
  input  logic                START,
  output logic [NIBBLE_W-1:0] D_OUT,
  output logic                LOAD_EN,
  output logic                BUSY,
  output logic                FRAME_ERR
);

  state_t     state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  nibble_t    shreg, shreg_n, shifted, first_bit;
  nibble_t    d_out_n;
  logic       load_en_n, busy_n, frame_err_n;
  logic       frame_start;
  logic       tmr_run, tmr_clear, tmr_expired;

  function automatic nibble_t shift_in(input nibble_t cur, input logic b);
    if (MSB_FIRST != 0) return {cur[NIBBLE_W-2:0], b};
    else                return {b, cur[NIBBLE_W-1:1]};
  endfunction

  assign frame_start = START && SIN_VALID;
  assign shifted     = shift_in(shreg, SIN);
  assign first_bit   = shift_in('0, SIN);
  assign tmr_clear   = ~tmr_run;

  nibble_deser_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .CLK     (CLK),
    .RESET   (RESET),
    .clear   (tmr_clear),
    .run     (tmr_run),
    .expired (tmr_expired)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      D_OUT     <= '0;
      LOAD_EN   <= 1'b0;
      BUSY      <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      D_OUT     <= d_out_n;
      LOAD_EN   <= load_en_n;
      BUSY      <= busy_n;
      FRAME_ERR <= frame_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shreg_n     = shreg;
    d_out_n     = D_OUT;
    load_en_n   = 1'b0;
    frame_err_n = 1'b0;
    tmr_run     = 1'b0;

    case (state)
      ST_SHIFT: begin
        if (frame_start) begin
          shreg_n   = first_bit;
          bit_cnt_n = 3'd1;
        end else if (SIN_VALID) begin
          shreg_n   = shifted;
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'(NIBBLE_W - 1)) begin
`ifdef NIBBLE_DESER_PARITY_EN
            state_n   = ST_PARITY;
`else
            state_n   = ST_LOAD;
            load_en_n = 1'b1;
            d_out_n   = shifted;
            bit_cnt_n = 3'd0;
`endif
          end
        end else begin
          tmr_run = 1'b1;
          if (tmr_expired) begin
            state_n     = ST_IDLE;
            frame_err_n = 1'b1;
            bit_cnt_n   = 3'd0;
          end
        end
      end

`ifdef NIBBLE_DESER_PARITY_EN
      ST_PARITY: begin
        if (frame_start) begin
          state_n   = ST_SHIFT;
          shreg_n   = first_bit;
          bit_cnt_n = 3'd1;
        end else if (SIN_VALID) begin
          bit_cnt_n = 3'd0;
          if (parity_ok(shreg, SIN)) begin
            state_n   = ST_LOAD;
            load_en_n = 1'b1;
            d_out_n   = shreg;
          end else begin
            state_n     = ST_IDLE;
            frame_err_n = 1'b1;
          end
        end else begin
          tmr_run = 1'b1;
          if (tmr_expired) begin
            state_n     = ST_IDLE;
            frame_err_n = 1'b1;
            bit_cnt_n   = 3'd0;
          end
        end
      end
`endif

      // IDLE and LOAD behave alike: LOAD lasts one cycle and may start a frame.
      default: begin
        state_n   = ST_IDLE;
        bit_cnt_n = 3'd0;
        if (frame_start) begin
          state_n   = ST_SHIFT;
          shreg_n   = first_bit;
          bit_cnt_n = 3'd1;
        end
      end
    endcase

`ifdef NIBBLE_DESER_PARITY_EN
    busy_n = (state_n == ST_SHIFT) || (state_n == ST_PARITY);
`else
    busy_n = (state_n == ST_SHIFT);
`endif
  end

endmodule

// File: tb/tb_nibble_deserializer.sv
// Randomized bench for nibble_deserializer: an MSB-first/timeout-8 instance and
// an LSB-first/timeout-3 instance share stimulus and are checked every cycle.
module tb_nibble_deserializer;

`ifdef NIBBLE_DESER_PARITY_EN
  localparam int FRAME_LEN = 5;
`else
  localparam int FRAME_LEN = 4;
`endif

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       SIN = 1'b0;
  logic       SIN_VALID = 1'b0;
  logic       START = 1'b0;
  logic [3:0] d_m, d_l;
  logic       ld_m, ld_l, busy_m, busy_l, err_m, err_l;

  int n_checks = 0;
  int n_errors = 0;
  int ld_cnt_m = 0;
  int err_cnt_m = 0;

  // Reference model state, index 0 = dut_m, 1 = dut_l
  bit         m_active[2];
  bit         m_bits[2][5];
  int         m_len[2];
  int         m_idle[2];
  logic [3:0] e_d[2];
  bit         e_ld[2], e_busy[2], e_err[2];

  always #5 CLK = ~CLK;

  nibble_deserializer #(.MSB_FIRST(1), .TIMEOUT_CYCLES(8)) dut_m (
    .CLK(CLK), .RESET(RESET), .SIN(SIN), .SIN_VALID(SIN_VALID), .START(START),
    .D_OUT(d_m), .LOAD_EN(ld_m), .BUSY(busy_m), .FRAME_ERR(err_m)
  );

  nibble_deserializer #(.MSB_FIRST(0), .TIMEOUT_CYCLES(3)) dut_l (
    .CLK(CLK), .RESET(RESET), .SIN(SIN), .SIN_VALID(SIN_VALID), .START(START),
    .D_OUT(d_l), .LOAD_EN(ld_l), .BUSY(busy_l), .FRAME_ERR(err_l)
  );

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int timeout_of(input int m);
    return (m == 0) ? 8 : 3;
  endfunction

  function automatic bit frame_ok(input int m);
    int ones = 0;
    if (FRAME_LEN == 4) return 1'b1;
    for (int i = 0; i < FRAME_LEN; i++) ones += int'(m_bits[m][i]);
    return (ones % 2) == 0;
  endfunction

  function automatic logic [3:0] assemble(input int m);
    int val = 0;
    for (int i = 0; i < 4; i++) begin
      if (m == 0) val += int'(m_bits[m][i]) * (1 << (3 - i));
      else        val += int'(m_bits[m][i]) * (1 << i);
    end
    return 4'(val);
  endfunction

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      m_active[m] = 1'b0;
      m_len[m]    = 0;
      m_idle[m]   = 0;
      e_d[m]      = 4'd0;
      e_ld[m]     = 1'b0;
      e_busy[m]   = 1'b0;
      e_err[m]    = 1'b0;
    end
  endfunction

  // Expected registered outputs after the edge on which these inputs are sampled.
  function automatic void model_step(input int m, input bit sin, input bit valid, input bit start);
    e_ld[m]  = 1'b0;
    e_err[m] = 1'b0;
    if (valid && start) begin
      m_bits[m][0] = sin;
      m_len[m]     = 1;
      m_active[m]  = 1'b1;
      m_idle[m]    = 0;
    end else if (m_active[m]) begin
      if (valid) begin
        m_bits[m][m_len[m]] = sin;
        m_len[m]++;
        m_idle[m] = 0;
        if (m_len[m] == FRAME_LEN) begin
          m_active[m] = 1'b0;
          if (frame_ok(m)) begin
            e_ld[m] = 1'b1;
            e_d[m]  = assemble(m);
          end else begin
            e_err[m] = 1'b1;
          end
        end
      end else begin
        m_idle[m]++;
        if (m_idle[m] == timeout_of(m)) begin
          m_active[m] = 1'b0;
          e_err[m]    = 1'b1;
        end
      end
    end
    e_busy[m] = m_active[m];
  endfunction

  task automatic compare_all();
    check_val("m.d_out",     8'(d_m),    8'(e_d[0]));
    check_val("m.load_en",   8'(ld_m),   8'(e_ld[0]));
    check_val("m.busy",      8'(busy_m), 8'(e_busy[0]));
    check_val("m.frame_err", 8'(err_m),  8'(e_err[0]));
    check_val("m.excl",      8'(ld_m & err_m), 8'd0);
    check_val("l.d_out",     8'(d_l),    8'(e_d[1]));
    check_val("l.load_en",   8'(ld_l),   8'(e_ld[1]));
    check_val("l.busy",      8'(busy_l), 8'(e_busy[1]));
    check_val("l.frame_err", 8'(err_l),  8'(e_err[1]));
  endtask

  task automatic tick(input logic sin, input logic valid, input logic start);
    @(negedge CLK);
    SIN = sin;
    SIN_VALID = valid;
    START = start;
    model_step(0, sin, valid, start);
    model_step(1, sin, valid, start);
    @(posedge CLK);
    #1;
    if (ld_m)  ld_cnt_m++;
    if (err_m) err_cnt_m++;
    compare_all();
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RESET = 1'b1;
    SIN_VALID = 1'b0;
    START = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  // Frame bits are sent f[3] first; parity bit appended when enabled.
  task automatic send_frame(input logic [3:0] f);
    for (int i = 3; i >= 0; i--) tick(f[i], 1'b1, i == 3);
`ifdef NIBBLE_DESER_PARITY_EN
    tick(^f, 1'b1, 1'b0);
`endif
  endtask

  initial begin
    int vprob;
    model_reset();
    repeat (2) @(negedge CLK);
    #1;
    compare_all();
    RESET = 1'b0;

    send_frame(4'b1011);
    check_val("msb_first.load", 8'(ld_m), 8'd1);
    check_val("msb_first.d",    8'(d_m),  8'hB);
    check_val("lsb_first.d",    8'(d_l),  8'hD);

    ld_cnt_m = 0;
    send_frame(4'b0110);
    check_val("b2b.first_d", 8'(d_m), 8'h6);
    send_frame(4'b1001);
    check_val("b2b.second_load", 8'(ld_m), 8'd1);
    check_val("b2b.second_d",    8'(d_m),  8'h9);
    check_val("b2b.loads",       8'(ld_cnt_m), 8'd2);

    ld_cnt_m = 0;
    err_cnt_m = 0;
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b0);
    repeat (7) tick(1'b0, 1'b0, 1'b0);
    check_val("timeout.early", 8'(err_cnt_m), 8'd0);
    tick(1'b0, 1'b0, 1'b0);
    check_val("timeout.pulse", 8'(err_m), 8'd1);
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    check_val("timeout.count", 8'(err_cnt_m), 8'd1);
    check_val("timeout.noload", 8'(ld_cnt_m), 8'd0);
    check_val("timeout.d_hold", 8'(d_m), 8'h9);

    tick(1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    apply_reset();
    ld_cnt_m = 0;
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    check_val("rst.noload", 8'(ld_cnt_m), 8'd0);
    check_val("rst.d",      8'(d_m), 8'h0);

    // Restart mid-frame must discard the partial frame silently.
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b0);
    send_frame(4'b0011);
    check_val("restart.d", 8'(d_m), 8'h3);

    for (int i = 0; i < 4000; i++) begin
      case ((i / 40) % 3)
        0:       vprob = 85;
        1:       vprob = 45;
        default: vprob = 8;
      endcase
      tick(1'($urandom_range(0, 1)),
           1'($urandom_range(0, 99) < vprob),
           1'($urandom_range(0, 99) < 10));
      if ((i % 1000) == 999) apply_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
